// File: rtl/imem_loader_pkg.sv
// Shared ISA-side constants for the instruction memory and its loader.
// State encodings are plain constants so older blocks can compare against them.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W      = 10;
  localparam int INSTR_W          = 16;
  localparam int LOADER_MAX_WORDS = 1 << IMEM_ADDR_W;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] LEN_HI  = 3'd0;
  localparam logic [STATE_W-1:0] LEN_LO  = 3'd1;
  localparam logic [STATE_W-1:0] DATA_HI = 3'd2;
  localparam logic [STATE_W-1:0] DATA_LO = 3'd3;
  localparam logic [STATE_W-1:0] SUM_HI  = 3'd4;
  localparam logic [STATE_W-1:0] SUM_LO  = 3'd5;
  localparam logic [STATE_W-1:0] DONE    = 3'd6;
  localparam logic [STATE_W-1:0] ERROR   = 3'd7;

  // A frame must carry at least one word and no more than the memory holds.
  function automatic logic len_ok(input logic [15:0] len, input int max_words);
    return (len != 16'd0) && ({16'd0, len} <= $unsigned(max_words));
  endfunction

  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/loader_byte_pair.sv
// Pairs a latched high byte with the live low byte into a big-endian word
// and keeps the running 16-bit additive checksum of the data words.
module loader_byte_pair
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_load,
  input  logic        sum_clear,
  input  logic        sum_add,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic [15:0] checksum
);

  logic [7:0]  hi_r;
  logic [15:0] sum_r;

  assign word     = {hi_r, byte_in};
  assign checksum = sum_r;

  // High-byte holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 8'd0;
    end else if (hi_load) begin
      hi_r <= byte_in;
    end
  end

  // Checksum accumulator; clear wins over add so a restart never carries stale data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r <= 16'd0;
    end else if (sum_clear) begin
      sum_r <= 16'd0;
    end else if (sum_add) begin
      sum_r <= sum16(sum_r, word);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a framed byte stream and holds the CPU in
// reset until a complete image with a matching checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = INSTR_W,
  parameter int MAX_WORDS = LOADER_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_nxt_s;

  logic [ADDR_W:0]    count_r;
  logic [ADDR_W:0]    idx_r;

  logic               imem_we_r;
  logic [ADDR_W-1:0]  imem_waddr_r;
  logic [DATA_W-1:0]  imem_wdata_r;
  logic               cpu_reset_r;
  logic               done_r;
  logic               error_r;

  logic               accept_s;
  logic               hi_load_s;
  logic               write_s;
  logic               len_good_s;
  logic               restart_s;
  logic               last_word_s;
  logic [15:0]        pair_word_s;
  logic [15:0]        checksum_s;

  // Ready depends on state alone so the upstream handshake has no loop through in_valid.
  assign in_ready  = (state_r != DONE) && (state_r != ERROR);
  assign accept_s  = in_valid && in_ready;

  assign hi_load_s   = accept_s && ((state_r == LEN_HI) || (state_r == DATA_HI) || (state_r == SUM_HI));
  assign write_s     = accept_s && (state_r == DATA_LO);
  assign len_good_s  = accept_s && (state_r == LEN_LO) && len_ok(pair_word_s, MAX_WORDS);
  assign restart_s   = reload && ((state_r == DONE) || (state_r == ERROR));
  assign last_word_s = ((idx_r + IDX_ONE) == count_r);

  loader_byte_pair u_byte_pair (
    .clk       (clk),
    .reset     (reset),
    .hi_load   (hi_load_s),
    .sum_clear (len_good_s || restart_s),
    .sum_add   (write_s),
    .byte_in   (in_data),
    .word      (pair_word_s),
    .checksum  (checksum_s)
  );

  // Next-state decode for the frame parser
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LEN_HI: begin
        if (accept_s) state_nxt_s = LEN_LO;
        else          state_nxt_s = LEN_HI;
      end
      LEN_LO: begin
        if (!accept_s)       state_nxt_s = LEN_LO;
        else if (len_good_s) state_nxt_s = DATA_HI;
        else                 state_nxt_s = ERROR;
      end
      DATA_HI: begin
        if (accept_s) state_nxt_s = DATA_LO;
        else          state_nxt_s = DATA_HI;
      end
      DATA_LO: begin
        if (!accept_s)        state_nxt_s = DATA_LO;
        else if (last_word_s) state_nxt_s = SUM_HI;
        else                  state_nxt_s = DATA_HI;
      end
      SUM_HI: begin
        if (accept_s) state_nxt_s = SUM_LO;
        else          state_nxt_s = SUM_HI;
      end
      SUM_LO: begin
        if (!accept_s)                      state_nxt_s = SUM_LO;
        else if (pair_word_s == checksum_s) state_nxt_s = DONE;
        else                                state_nxt_s = ERROR;
      end
      DONE, ERROR: begin
        if (reload) state_nxt_s = LEN_HI;
        else        state_nxt_s = state_r;
      end
      default: state_nxt_s = ERROR;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= LEN_HI;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered memory write port; address and data hold between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we_r    <= 1'b0;
      imem_waddr_r <= '0;
      imem_wdata_r <= '0;
    end else begin
      imem_we_r <= write_s;
      if (write_s) begin
        imem_waddr_r <= idx_r[ADDR_W-1:0];
        imem_wdata_r <= DATA_W'(pair_word_s);
      end
    end
  end

  // Word count and write index; LEN is range-checked so the index cannot wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      idx_r   <= '0;
    end else if (len_good_s) begin
      count_r <= pair_word_s[ADDR_W:0];
      idx_r   <= '0;
    end else if (write_s) begin
      idx_r   <= idx_r + IDX_ONE;
    end else if (restart_s) begin
      count_r <= '0;
      idx_r   <= '0;
    end
  end

  // Status flags track the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      cpu_reset_r <= (state_nxt_s != DONE);
      done_r      <= (state_nxt_s == DONE);
      error_r     <= (state_nxt_s == ERROR);
    end
  end

  assign imem_we    = imem_we_r;
  assign imem_waddr = imem_waddr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
